adc_sequencer: RTL and testbench
================================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter PERIOD, 200: minimum clk cycles between consecutive adc_start pulses.
REQ-002 Parameter TIMEOUT, 400: max cycles from adc_start to adc_data_enable rise.
REQ-003 Parameter RST_CYCLES, 4: adc_reset pulse width in cycles.
REQ-004 Parameter SETTLE, 64: wait cycles after adc_reset falls before next trigger.
REQ-005 Parameter MAX_RETRY, 3: consecutive recoveries allowed before FAULT.
REQ-006 Ports SHALL be (name direction width meaning): clk in 1 system clock; reset in 1 asynchronous active-low reset; run in 1 acquisition enable; burst_len in 16 samples per burst, 0 = continuous; adc_start out 1 start_acquisition to controller; adc_reset out 1 active-high synchronous reset to controller; adc_data_enable in 1 controller data valid level; adc_is_error in 1 controller error; adc_data in 16 controller sample; sample_valid out 1; sample_ready in 1; sample_data out 16; sample_last out 1 final sample of burst; busy out 1; fault out 1; overflow out 1 sticky dropped-sample flag; error_count out 8 saturating recovery count.

Function
REQ-007 States SHALL be INIT_RST, INIT_WAIT, IDLE, TRIGGER, WAIT_DATA, WAIT_DONE, WAIT_PERIOD, REC_RST, REC_WAIT, FAULT.
REQ-008 Period counter SHALL clear in TRIGGER, increment every cycle otherwise, saturate at PERIOD-1; "expired" = value PERIOD-1.
REQ-009 INIT_RST: adc_reset=1 for RST_CYCLES cycles -> INIT_WAIT (adc_reset=0) for SETTLE cycles -> IDLE; error_count not incremented.
REQ-010 IDLE: when run=1 and period expired -> latch burst_len, clear sample count and retry count, -> TRIGGER.
REQ-011 TRIGGER: adc_start=1 for exactly this one cycle -> WAIT_DATA; adc_start=0 in all other states.
REQ-012 WAIT_DATA: on adc_data_enable 0->1 edge (registered previous value) capture adc_data, increment sample count, clear retry count -> WAIT_DONE; after TIMEOUT cycles without edge -> REC_RST.
REQ-013 Captured sample SHALL load the output register if sample_valid=0 or sample_ready=1 in that cycle; otherwise sample is dropped and overflow set until reset.
REQ-014 sample_valid SHALL hold with stable sample_data/sample_last until sample_valid&sample_ready; transfer clears sample_valid next cycle unless a new sample loads.
REQ-015 sample_last SHALL be 1 when burst_len!=0 and sample count after increment equals latched burst_len; always 0 in continuous mode.
REQ-016 WAIT_DONE: on adc_data_enable=0 -> WAIT_PERIOD.
REQ-017 WAIT_PERIOD: when period expired -> IDLE if run=0 or burst complete, else TRIGGER; trigger spacing therefore exactly PERIOD cycles when controller finishes early.
REQ-018 adc_is_error=1 in TRIGGER, WAIT_DATA, WAIT_DONE, WAIT_PERIOD or IDLE SHALL take priority -> REC_RST, incrementing error_count (saturate 255) and retry count.
REQ-019 REC_RST: adc_reset=1 for RST_CYCLES -> REC_WAIT SETTLE cycles -> FAULT if retry count > MAX_RETRY, else TRIGGER if run=1 (burst resumes, count kept), else IDLE.
REQ-020 FAULT: fault=1, no triggers; run=0 -> IDLE with fault=0 and retry cleared.
REQ-021 busy SHALL be 1 in all states except IDLE and FAULT.
REQ-022 run falling mid-burst SHALL NOT abort a conversion; sequence completes through WAIT_PERIOD then IDLE.
REQ-023 burst_len changes SHALL affect only the next burst.

Reset
REQ-024 reset=0 asynchronously SHALL force INIT_RST, adc_reset=1, adc_start=0, sample_valid=0, sample_data=0, sample_last=0, busy=1, fault=0, overflow=0, error_count=0, all counters 0, period counter saturated.
REQ-025 Reset asserted mid-conversion SHALL discard pending sample; after release full INIT sequence runs before any trigger.

Verification
REQ-026 Release reset, run=1, burst_len=3, ready=1, controller model returns 0x1234 -> adc_reset high 4 cycles, first adc_start after 64-cycle settle, three starts 200 cycles apart, third sample sample_last=1, then IDLE, busy=0.
REQ-027 burst_len=0, sample_ready=0 -> first sample held valid, second sample dropped, overflow=1 and stays 1.
REQ-028 Controller never raises data_enable -> REC_RST 400 cycles after adc_start, error_count=1, retry trigger after 4+64 cycles; fourth consecutive timeout -> fault=1, busy=0; run=0 -> fault=0.
REQ-029 adc_is_error pulse in WAIT_PERIOD -> adc_reset 4 cycles, error_count increments, burst resumes with sample count preserved.
REQ-030 run dropped one cycle after adc_start -> sample still delivered, no further adc_start, IDLE after period expiry.

Source files
------------

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - ADC controller sequencer: paced triggering, sample capture, timeout/error recovery.
module adc_sequencer #(
   parameter int PERIOD     = 200,
   parameter int TIMEOUT    = 400,
   parameter int RST_CYCLES = 4,
   parameter int SETTLE     = 64,
   parameter int MAX_RETRY  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] burst_len,
   output logic        adc_start,
   output logic        adc_reset,
   input  logic        adc_data_enable,
   input  logic        adc_is_error,
   input  logic [15:0] adc_data,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic [15:0] sample_data,
   output logic        sample_last,
   output logic        busy,
   output logic        fault,
   output logic        overflow,
   output logic [7:0]  error_count
);

   typedef enum logic [3:0] {
      INIT_RST,
      INIT_WAIT,
      IDLE,
      TRIGGER,
      WAIT_DATA,
      WAIT_DONE,
      WAIT_PERIOD,
      REC_RST,
      REC_WAIT,
      FAULT
   } state_t;

   localparam logic [15:0] PERIOD_LAST  = 16'(PERIOD - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE - 1);
   localparam logic [7:0]  RETRY_MAX    = 8'(MAX_RETRY);

   state_t      state, state_nx;
   logic [15:0] timer, timer_nx;
   logic [15:0] period_cnt;
   logic [15:0] burst_lat;
   logic [15:0] sample_cnt;
   logic [15:0] sample_cnt_inc;
   logic [7:0]  retry_cnt;
   logic        de_prev;

   logic period_expired;
   logic de_rise;
   logic burst_done;
   logic err_watch;
   logic start_burst;
   logic capture;
   logic recover;
   logic clear_retry;

   assign period_expired = (period_cnt == PERIOD_LAST);
   assign de_rise        = adc_data_enable & ~de_prev;
   assign sample_cnt_inc = sample_cnt + 16'd1;
   assign burst_done     = (burst_lat != 16'd0) && (sample_cnt == burst_lat);
   assign err_watch      = (state == IDLE) || (state == TRIGGER) || (state == WAIT_DATA) ||
                           (state == WAIT_DONE) || (state == WAIT_PERIOD);

   assign adc_start = (state == TRIGGER);
   assign adc_reset = (state == INIT_RST) || (state == REC_RST);
   assign busy      = (state != IDLE) && (state != FAULT);
   assign fault     = (state == FAULT);

   always_comb begin
      state_nx    = state;
      start_burst = 1'b0;
      capture     = 1'b0;
      recover     = 1'b0;
      clear_retry = 1'b0;
      case (state)
         INIT_RST:    if (timer == RST_LAST) state_nx = INIT_WAIT;
         INIT_WAIT:   if (timer == SETTLE_LAST) state_nx = IDLE;
         IDLE: begin
            if (run && period_expired) begin
               start_burst = 1'b1;
               state_nx    = TRIGGER;
            end
         end
         TRIGGER:     state_nx = WAIT_DATA;
         WAIT_DATA: begin
            if (de_rise) begin
               capture  = 1'b1;
               state_nx = WAIT_DONE;
            end else if (timer == TIMEOUT_LAST) begin
               recover  = 1'b1;
               state_nx = REC_RST;
            end
         end
         WAIT_DONE:   if (!adc_data_enable) state_nx = WAIT_PERIOD;
         WAIT_PERIOD: begin
            if (period_expired) state_nx = (!run || burst_done) ? IDLE : TRIGGER;
         end
         REC_RST:     if (timer == RST_LAST) state_nx = REC_WAIT;
         REC_WAIT: begin
            if (timer == SETTLE_LAST) begin
               if (retry_cnt > RETRY_MAX)      state_nx = FAULT;
               else if (run && !burst_done)    state_nx = TRIGGER;
               else                            state_nx = IDLE;
            end
         end
         FAULT: begin
            if (!run) begin
               clear_retry = 1'b1;
               state_nx    = IDLE;
            end
         end
         default:     state_nx = INIT_RST;
      endcase
      // A controller error overrides any progress made in the same cycle.
      if (err_watch && adc_is_error) begin
         state_nx    = REC_RST;
         recover     = 1'b1;
         capture     = 1'b0;
         start_burst = 1'b0;
      end
   end

   // WAIT_DATA starts at 1 so the timer there counts cycles since adc_start.
   always_comb begin
      timer_nx = timer + 16'd1;
      if (state_nx != state) timer_nx = (state_nx == WAIT_DATA) ? 16'd1 : 16'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= INIT_RST;
         timer        <= 16'd0;
         period_cnt   <= PERIOD_LAST;
         burst_lat    <= 16'd0;
         sample_cnt   <= 16'd0;
         retry_cnt    <= 8'd0;
         de_prev      <= 1'b0;
         sample_valid <= 1'b0;
         sample_data  <= 16'd0;
         sample_last  <= 1'b0;
         overflow     <= 1'b0;
         error_count  <= 8'd0;
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         de_prev <= adc_data_enable;

         if (state_nx == TRIGGER)  period_cnt <= 16'd0;
         else if (!period_expired) period_cnt <= period_cnt + 16'd1;

         if (start_burst) begin
            burst_lat  <= burst_len;
            sample_cnt <= 16'd0;
            retry_cnt  <= 8'd0;
         end
         if (capture) begin
            sample_cnt <= sample_cnt_inc;
            retry_cnt  <= 8'd0;
         end
         if (recover) begin
            if (retry_cnt != 8'hff)   retry_cnt   <= retry_cnt + 8'd1;
            if (error_count != 8'hff) error_count <= error_count + 8'd1;
         end
         if (clear_retry) retry_cnt <= 8'd0;

         if (capture && (!sample_valid || sample_ready)) begin
            sample_valid <= 1'b1;
            sample_data  <= adc_data;
            sample_last  <= (burst_lat != 16'd0) && (sample_cnt_inc == burst_lat);
         end else begin
            if (sample_ready) sample_valid <= 1'b0;
            if (capture)      overflow     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - Scoreboard bench for adc_sequencer with a behavioural controller model.
module tb_adc_sequencer;

   logic        clk = 1'b0;
   logic        reset, run, adc_data_enable, adc_is_error, sample_ready;
   logic [15:0] burst_len, adc_data, sample_data;
   logic        adc_start, adc_reset, sample_valid, sample_last, busy, fault, overflow;
   logic [7:0]  error_count;

   always #5 clk = ~clk;

   adc_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .burst_len(burst_len),
      .adc_start(adc_start), .adc_reset(adc_reset),
      .adc_data_enable(adc_data_enable), .adc_is_error(adc_is_error), .adc_data(adc_data),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
      .sample_last(sample_last), .busy(busy), .fault(fault), .overflow(overflow),
      .error_count(error_count)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          rst_run  = 0;
   int          starts_q[$];
   int          rise_q[$];
   int          fall_q[$];
   int          width_q[$];
   logic [16:0] exp_q[$];
   logic [16:0] mon_exp;
   logic [16:0] dropped;
   bit          ctrl_en   = 1'b1;
   logic [15:0] ctrl_val  = 16'h1234;
   logic [15:0] ctrl_step = 16'h0000;
   int          tb_burst  = 0;
   int          tb_cnt    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Event recorder and scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (adc_start) starts_q.push_back(cyc);
      if (reset && adc_reset) begin
         if (rst_run == 0) rise_q.push_back(cyc);
         rst_run++;
      end else begin
         if (reset && rst_run > 0) begin
            width_q.push_back(rst_run);
            fall_q.push_back(cyc);
         end
         rst_run = 0;
      end
      if (sample_valid && sample_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sample_unexpected: got data %h last %0b, expected no sample", sample_data, sample_last);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({sample_last, sample_data} !== mon_exp) begin
               n_fail++;
               $display("FAIL sample: got data %h last %0b, expected data %h last %0b",
                        sample_data, sample_last, mon_exp[15:0], mon_exp[16]);
            end
         end
      end
   end

   // Controller model: answers each adc_start with one data_enable pulse and predicts the sample.
   initial begin
      adc_data_enable = 1'b0;
      adc_data        = 16'h0000;
      forever begin
         @(negedge clk);
         if (adc_start && ctrl_en) begin
            repeat (10) @(posedge clk);
            #1;
            tb_cnt++;
            exp_q.push_back({(tb_burst != 0 && tb_cnt == tb_burst), ctrl_val});
            adc_data        = ctrl_val;
            ctrl_val        = ctrl_val + ctrl_step;
            adc_data_enable = 1'b1;
            repeat (3) @(posedge clk);
            #1 adc_data_enable = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int budget, input string name);
      int i = 0;
      @(negedge clk);
      while (!adc_start && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(name, adc_start, 1);
      #1;
   endtask

   task automatic wait_rise(input int n0, input int budget, input string name);
      int i = 0;
      while (rise_q.size() <= n0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      #1;
      chk(name, rise_q.size() > n0, 1);
   endtask

   task automatic wait_empty(input int budget, input string name);
      int i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      #1;
      chk(name, exp_q.size() == 0, 1);
   endtask

   initial begin
      int s0, r0, i;
      reset        = 1'b0;
      run          = 1'b0;
      burst_len    = 16'd0;
      adc_is_error = 1'b0;
      sample_ready = 1'b1;
      step(3);

      @(negedge clk);
      chk("rst_adc_reset", adc_reset, 1);
      chk("rst_adc_start", adc_start, 0);
      chk("rst_sample_valid", sample_valid, 0);
      chk("rst_sample_data", sample_data, 0);
      chk("rst_sample_last", sample_last, 0);
      chk("rst_busy", busy, 1);
      chk("rst_fault", fault, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_error_count", error_count, 0);

      // Three-sample burst of 0x1234 after power-up initialisation.
      @(posedge clk);
      #1;
      reset = 1'b1; run = 1'b1; burst_len = 16'd3; tb_burst = 3; tb_cnt = 0;
      wait_start(200, "burst_start1");
      chk("init_rst_width", width_q[0], 4);
      chk("settle_to_start", starts_q[0] - fall_q[0], 65);
      wait_start(250, "burst_start2");
      chk("start_spacing_12", starts_q[1] - starts_q[0], 200);
      wait_start(250, "burst_start3");
      chk("start_spacing_23", starts_q[2] - starts_q[1], 200);
      step(1);
      run = 1'b0;
      wait_empty(60, "burst_samples_done");
      step(250);
      chk("burst_idle_busy", busy, 0);
      chk("burst_start_count", starts_q.size(), 3);

      // Continuous mode with a stalled consumer: first sample held, second dropped.
      ctrl_val = 16'hA000; ctrl_step = 16'h0001; tb_burst = 0; tb_cnt = 0;
      burst_len = 16'd0; sample_ready = 1'b0; run = 1'b1;
      wait_start(250, "cont_start1");
      step(30);
      chk("cont_hold_valid", sample_valid, 1);
      chk("cont_no_overflow_yet", overflow, 0);
      wait_start(250, "cont_start2");
      step(1);
      run = 1'b0;
      step(30);
      chk("cont_overflow_set", overflow, 1);
      chk("cont_still_valid", sample_valid, 1);
      dropped = exp_q.pop_back();
      sample_ready = 1'b1;
      step(3);
      chk("cont_drained", exp_q.size(), 0);
      chk("cont_valid_clear", sample_valid, 0);
      chk("cont_overflow_sticky", overflow, 1);
      step(200);

      // Silent controller: four consecutive timeouts end in FAULT.
      ctrl_en = 1'b0; burst_len = 16'd1; run = 1'b1;
      s0 = starts_q.size();
      r0 = rise_q.size();
      wait_start(300, "to_start");
      wait_rise(r0, 450, "to_rise1");
      chk("timeout_latency", rise_q[$] - starts_q[$], 400);
      step(2);
      chk("to_error_count1", error_count, 1);
      wait_start(100, "to_retry_start");
      chk("retry_delay", starts_q[$] - rise_q[$], 68);
      for (int k = 2; k <= 4; k++) begin
         wait_rise(r0 + k - 1, 500, "to_rise_n");
         step(2);
         chk("to_error_count_n", error_count, k);
      end
      i = 0;
      while (!fault && i < 100) begin
         step(1);
         i++;
      end
      chk("fault_set", fault, 1);
      chk("fault_busy", busy, 0);
      chk("fault_start_count", starts_q.size() - s0, 4);
      run = 1'b0;
      step(2);
      chk("fault_cleared", fault, 0);
      ctrl_en = 1'b1;

      // Error pulse during WAIT_PERIOD: recover and finish the burst.
      ctrl_val = 16'h5A00; ctrl_step = 16'h0011; tb_burst = 2; tb_cnt = 0;
      burst_len = 16'd2; run = 1'b1;
      s0 = starts_q.size();
      wait_start(250, "err_start1");
      wait_empty(40, "err_sample1");
      step(30);
      r0 = rise_q.size();
      adc_is_error = 1'b1;
      step(1);
      adc_is_error = 1'b0;
      wait_rise(r0, 5, "err_rise");
      step(8);
      chk("err_reset_width", width_q[$], 4);
      chk("err_error_count", error_count, 5);
      wait_start(100, "err_resume_start");
      chk("err_resume_delay", starts_q[$] - rise_q[$], 68);
      step(1);
      run = 1'b0;
      wait_empty(40, "err_sample2");
      step(250);
      chk("err_start_count", starts_q.size() - s0, 2);
      chk("err_idle_busy", busy, 0);

      // run dropped right after adc_start: conversion still delivered.
      ctrl_val = 16'hBEEF; ctrl_step = 16'h0000; tb_burst = 5; tb_cnt = 0;
      burst_len = 16'd5; run = 1'b1;
      s0 = starts_q.size();
      wait_start(250, "drop_start");
      step(1);
      run = 1'b0;
      wait_empty(60, "drop_sample");
      step(400);
      chk("drop_start_count", starts_q.size() - s0, 1);
      chk("drop_idle_busy", busy, 0);
      chk("drop_overflow_sticky", overflow, 1);

      // Reset mid-conversion discards the held sample and reruns initialisation.
      ctrl_val = 16'h0F0F; tb_burst = 1; tb_cnt = 0;
      burst_len = 16'd1; sample_ready = 1'b0; run = 1'b1;
      wait_start(250, "rr_start");
      i = 0;
      while (!sample_valid && i < 30) begin
         step(1);
         i++;
      end
      chk("rr_sample_held", sample_valid, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("rr_valid_discarded", sample_valid, 0);
      chk("rr_data_cleared", sample_data, 0);
      chk("rr_adc_reset", adc_reset, 1);
      chk("rr_busy", busy, 1);
      chk("rr_overflow_cleared", overflow, 0);
      chk("rr_error_count_cleared", error_count, 0);
      dropped = exp_q.pop_back();
      sample_ready = 1'b1;
      tb_cnt = 0;
      step(5);
      reset = 1'b1;
      wait_start(120, "rr_restart");
      chk("rr_init_width", width_q[$], 4);
      chk("rr_settle_to_start", starts_q[$] - fall_q[$], 65);
      step(1);
      run = 1'b0;
      wait_empty(40, "rr_sample");
      step(250);
      chk("rr_idle_busy", busy, 0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
